rle_run_encoder: RTL and testbench

- Parametrised run-length encoder for the rover vision pipeline. Successor to the fixed three-stream bit encoder.
- Converts a per-pixel classified bit stream into {value, length, eol, eof} run tokens.
- Tokens go into an internal FIFO with a valid/ready output, so short, rapidly alternating runs and runs at line edges are never merged or lost while space remains.
- Sits between the pixel classifier and the downstream decoder/FIFO stage.

---
 rtl/rle_run_encoder_if.sv | 12 +
 rtl/rle_run_encoder.sv | 173 +++++++++++++++++
 tb/tb_rle_run_encoder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rle_run_encoder_if.sv
// Token output channel of rle_run_encoder: valid/ready handshake carrying
// {eof, eol, val, len} run tokens.
interface rle_run_encoder_if #(
    parameter int RUN_W = 11
);
    logic             tok_valid;
    logic             tok_ready;
    logic [RUN_W+2:0] tok_data;

    modport master (output tok_valid, output tok_data, input tok_ready);
    modport slave  (input tok_valid, input tok_data, output tok_ready);
endinterface

// File: rtl/rle_run_encoder.sv
// Run-length encoder: classified pixel bits -> {eof, eol, val, len} tokens through a
// first-word fall-through FIFO. Define RLE_TOKEN_COUNT_EN to add the frame_tokens output.
module rle_run_encoder #(
    parameter int RUN_W      = 11,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                          CLK,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          pix_bit,
    input  logic                          pix_eol,
    input  logic                          pix_eof,
    rle_run_encoder_if.master             tok,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          ovf_clr,
    output logic                          overflow
`ifdef RLE_TOKEN_COUNT_EN
    ,
    output logic [CNT_W-1:0]              frame_tokens
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [RUN_W-1:0] MAX_LEN = '1;
    localparam logic [RUN_W-1:0] LEN_ONE = RUN_W'(1);

    typedef logic [RUN_W+2:0] tok_t;
    typedef enum logic {IDLE, RUN} state_t;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
        $error("rle_run_encoder: FIFO_DEPTH must be a power of two >= 4 and CNT_W >= 1");
    end

    state_t           state, state_nx;
    logic             run_val, val_nx;
    logic [RUN_W-1:0] run_len, len_nx, len_inc;
    logic             eol_in;
    logic [1:0]       n_tok, n_wr;
    tok_t             tok0, tok1;

    // Decode emits up to two tokens per pixel; the FIFO commits both or neither.
    always_comb begin
        state_nx = state;
        val_nx   = run_val;
        len_nx   = run_len;
        n_tok    = 2'd0;
        tok0     = '0;
        tok1     = '0;
        eol_in   = pix_eol | pix_eof;
        len_inc  = run_len + 1'b1;
        if (enable) begin
            case (state)
                IDLE: begin
                    val_nx = pix_bit;
                    len_nx = LEN_ONE;
                    if (eol_in) begin
                        n_tok  = 2'd1;
                        tok0   = {pix_eof, 1'b1, pix_bit, LEN_ONE};
                        len_nx = '0;
                    end else begin
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (pix_bit == run_val) begin
                        if (!eol_in) begin
                            if (run_len != MAX_LEN) begin
                                len_nx = len_inc;
                            end else begin
                                n_tok  = 2'd1;
                                tok0   = {2'b00, run_val, MAX_LEN};
                                len_nx = LEN_ONE;
                            end
                        end else begin
                            state_nx = IDLE;
                            len_nx   = '0;
                            if (run_len != MAX_LEN) begin
                                n_tok = 2'd1;
                                tok0  = {pix_eof, 1'b1, run_val, len_inc};
                            end else begin
                                n_tok = 2'd2;
                                tok0  = {2'b00, run_val, MAX_LEN};
                                tok1  = {pix_eof, 1'b1, run_val, LEN_ONE};
                            end
                        end
                    end else begin
                        n_tok  = 2'd1;
                        tok0   = {2'b00, run_val, run_len};
                        val_nx = pix_bit;
                        len_nx = LEN_ONE;
                        if (eol_in) begin
                            n_tok    = 2'd2;
                            tok1     = {pix_eof, 1'b1, pix_bit, LEN_ONE};
                            state_nx = IDLE;
                            len_nx   = '0;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    tok_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, wr_ok, drop;
    logic [LW:0]   free_after;

    assign tok.tok_valid = (fifo_level != '0);
    assign tok.tok_data  = tok.tok_valid ? mem[rd_ptr] : '0;
    assign pop           = tok.tok_valid && tok.tok_ready;
    // The read of this cycle frees its slot before the write is judged.
    assign free_after    = (LW+1)'(FIFO_DEPTH) - {1'b0, fifo_level} + (LW+1)'(pop);
    assign wr_ok         = ((LW+1)'(n_tok) <= free_after);
    assign n_wr          = wr_ok ? n_tok : 2'd0;
    assign drop          = (n_tok != 2'd0) && !wr_ok;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            run_val    <= 1'b0;
            run_len    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            run_val    <= val_nx;
            run_len    <= len_nx;
            wr_ptr     <= wr_ptr + AW'(n_wr);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + LW'(n_wr) - LW'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (n_wr != 2'd0)
            mem[wr_ptr] <= tok0;
        if (n_wr == 2'd2)
            mem[wr_ptr + AW'(1)] <= tok1;
    end

`ifdef RLE_TOKEN_COUNT_EN
    logic [CNT_W-1:0] tok_cnt, cnt_sat;
    logic [CNT_W:0]   cnt_sum;
    logic             eof_emit;

    assign eof_emit = (n_tok == 2'd2) ? tok1[RUN_W+2] :
                      (n_tok == 2'd1) ? tok0[RUN_W+2] : 1'b0;
    assign cnt_sum  = {1'b0, tok_cnt} + (CNT_W+1)'(n_wr);
    assign cnt_sat  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    // A dropped eof token still closes the frame; only the published count is skipped.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            tok_cnt      <= '0;
            frame_tokens <= '0;
        end else if (eof_emit) begin
            tok_cnt <= '0;
            if (wr_ok)
                frame_tokens <= cnt_sat;
        end else begin
            tok_cnt <= cnt_sat;
        end
    end
`endif
endmodule

// File: tb/tb_rle_run_encoder.sv
// Self-checking bench for rle_run_encoder (RUN_W=4, FIFO_DEPTH=4): directed cases
// plus biased random stimulus against a run/queue reference model.
module tb_rle_run_encoder;
    localparam int RW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int TW    = RW + 3;
    localparam int MAXL  = (1 << RW) - 1;

    logic       CLK = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0, pix_bit = 1'b0, pix_eol = 1'b0, pix_eof = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
`ifdef RLE_TOKEN_COUNT_EN
    logic [CW-1:0] frame_tokens;
`endif

    rle_run_encoder_if #(.RUN_W(RW)) tok_if ();

    rle_run_encoder #(.RUN_W(RW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .enable     (enable),
        .pix_bit    (pix_bit),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .tok        (tok_if),
        .fifo_level (fifo_level),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow)
`ifdef RLE_TOKEN_COUNT_EN
        ,
        .frame_tokens (frame_tokens)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] mq[$];
    logic [TW-1:0] obs[$];
    bit  m_ovf, m_have, m_val;
    int  m_cnt, m_fc, m_ft;

    function automatic logic [TW-1:0] mk(bit v, int len, bit eol, bit eof);
        logic [RW-1:0] l;
        l = RW'(len);
        return {eof, eol, v, l};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tok_valid", 32'(tok_if.tok_valid), 32'(mq.size() != 0));
        if (mq.size() != 0)
            chk("tok_data", 32'(tok_if.tok_data), 32'(mq[0]));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef RLE_TOKEN_COUNT_EN
        chk("frame_tokens", 32'(frame_tokens), 32'(m_ft));
`endif
    endtask

    // Reference: a run closes on a value change, on eol, or when it would exceed MAXL.
    task automatic model_step(bit en, bit b, bit eol, bit eof, bit rdy, bit clr);
        logic [TW-1:0] em[$];
        bit has_eof;
        int sum;
        has_eof = 1'b0;
        if (en) begin
            if (m_have && b != m_val) begin
                em.push_back(mk(m_val, m_cnt, 0, 0));
                m_have = 1'b0;
            end
            if (m_have) m_cnt++;
            else begin
                m_have = 1'b1; m_val = b; m_cnt = 1;
            end
            if (m_cnt == MAXL + 1) begin
                em.push_back(mk(m_val, MAXL, 0, 0));
                m_cnt = 1;
            end
            if (eol || eof) begin
                em.push_back(mk(m_val, m_cnt, 1, eof));
                m_have = 1'b0;
                has_eof = eof;
            end
        end
        if (mq.size() != 0 && rdy) void'(mq.pop_front());
        if (em.size() <= DEPTH - mq.size()) begin
            foreach (em[i]) mq.push_back(em[i]);
            sum = m_fc + em.size();
            if (sum > 65535) sum = 65535;
            if (has_eof) begin
                m_ft = sum; m_fc = 0;
            end else begin
                m_fc = sum;
            end
            if (clr) m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b1;
            if (has_eof) m_fc = 0;
        end
    endtask

    task automatic cyc(bit en, bit b, bit eol, bit eof, bit rdy, bit clr);
        check_outputs();
        enable = en; pix_bit = b; pix_eol = eol; pix_eof = eof;
        tok_if.tok_ready = rdy; ovf_clr = clr;
        if (tok_if.tok_valid && rdy) obs.push_back(tok_if.tok_data);
        model_step(en, b, eol, eof, rdy, clr);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset_n = 1'b0;
        enable = 1'b0; pix_eol = 1'b0; pix_eof = 1'b0; ovf_clr = 1'b0;
        #1;
        chk("rst_tok_valid", 32'(tok_if.tok_valid), 32'd0);
        chk("rst_tok_data", 32'(tok_if.tok_data), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        mq.delete(); obs.delete();
        m_ovf = 1'b0; m_have = 1'b0; m_val = 1'b0; m_cnt = 0; m_fc = 0; m_ft = 0;
        @(negedge CLK);
        reset_n = 1'b1;
    endtask

    task automatic chk_obs(string tag, int idx, logic [TW-1:0] exp);
        if (idx < obs.size()) chk(tag, 32'(obs[idx]), 32'(exp));
        else chk(tag, 32'hdead, 32'(exp));
    endtask

    initial begin
        bit b, pb;
        tok_if.tok_ready = 1'b0;
        do_reset();

        // 1,1,1,0,0 then 1 with eol
        cyc(1, 1, 0, 0, 1, 0); cyc(1, 1, 0, 0, 1, 0); cyc(1, 1, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 1, 0); cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 1, 1, 0, 1, 0);
        chk("t1_level_pair", 32'(fifo_level), 32'd2);
        drain(4);
        chk("t1_count", 32'(obs.size()), 32'd3);
        chk_obs("t1_tok0", 0, mk(1, 3, 0, 0));
        chk_obs("t1_tok1", 1, mk(0, 2, 0, 0));
        chk_obs("t1_tok2", 2, mk(1, 1, 1, 0));

        // 20 ones then a 21st with eol+eof: split at MAXL
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 1, 0);
        cyc(1, 1, 1, 1, 1, 0);
        drain(4);
        chk("t2_count", 32'(obs.size()), 32'd2);
        chk_obs("t2_tok0", 0, mk(1, 15, 0, 0));
        chk_obs("t2_tok1", 1, mk(1, 6, 1, 1));

        // alternating bits with a stalled sink overflow the 4-deep FIFO
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, i[0], 0, 0, 0, 0);
        chk("t3_level", 32'(fifo_level), 32'd4);
        chk("t3_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        drain(6);
        chk("t3_count", 32'(obs.size()), 32'd4);
        chk_obs("t3_tok0", 0, mk(0, 1, 0, 0));
        chk_obs("t3_tok1", 1, mk(1, 1, 0, 0));
        chk_obs("t3_tok2", 2, mk(0, 1, 0, 0));
        chk_obs("t3_tok3", 3, mk(1, 1, 0, 0));
        cyc(0, 0, 0, 0, 1, 1);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // enable gaps inside a run are not counted
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc(1, 1, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 1, 0);
        drain(4);
        chk("t4_count", 32'(obs.size()), 32'd2);
        chk_obs("t4_tok0", 0, mk(1, 5, 0, 0));
        chk_obs("t4_tok1", 1, mk(0, 1, 1, 0));

        // reset mid-run with three tokens queued
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, i[0], 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_level_before", 32'(fifo_level), 32'd3);
        do_reset();
        cyc(1, 1, 1, 0, 1, 0);
        drain(3);
        chk("t5_count", 32'(obs.size()), 32'd1);
        chk_obs("t5_tok0", 0, mk(1, 1, 1, 0));

`ifdef RLE_TOKEN_COUNT_EN
        do_reset();
        for (int l = 0; l < 3; l++) begin
            cyc(1, 0, 0, 0, 1, 0); cyc(1, 0, 0, 0, 1, 0);
            cyc(1, 1, 1, (l == 2), 1, 0);
        end
        chk("t6_frame_tokens", 32'(frame_tokens), 32'd6);
        drain(4);
`endif

        // biased random traffic
        do_reset();
        pb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            b = ($urandom_range(0, 99) < 80) ? pb : ~pb;
            pb = b;
            cyc(($urandom_range(0, 9) < 8), b,
                ($urandom_range(0, 29) == 0), ($urandom_range(0, 79) == 0),
                ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 8 : 3)),
                ($urandom_range(0, 19) == 0));
        end
        drain(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
